// File: rtl/hci_package.sv
// Shared types and widths for the HCI arbitration-tree scheduler.
// Optional statistics are built when HCI_ARB_SCHED_STATS_EN is defined.
package hci_package;

   typedef enum logic [1:0] {
      NORMAL   = 2'd0,
      BOOST    = 2'd1,
      COOLDOWN = 2'd2
   } hci_arb_sched_state_e;

   localparam int unsigned HCI_ARB_SCHED_STAT_W  = 32;
   localparam int unsigned HCI_ARB_SCHED_BOOST_W = 16;

endpackage

// File: rtl/hci_stall_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module hci_stall_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= '0;
      end else if (clear_i) begin
         r_cnt <= '0;
      end else if (inc_i && (r_cnt != '1)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign cnt_o = r_cnt;

endmodule

// File: rtl/hci_arbiter_tree_sched.sv
// Starvation-aware scheduler driving the HCI arbitration tree priority inversion.
// Define HCI_ARB_SCHED_STATS_EN to add per-requester stall totals and a boost-event counter.
module hci_arbiter_tree_sched
   import hci_package::*;
#(
   parameter  int unsigned NB_REQUESTS     = 2,
   parameter  int unsigned CNT_W           = 8,
   parameter  int unsigned COOLDOWN_CYCLES = 4,
   localparam int unsigned IDW             = $clog2(NB_REQUESTS)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   enable_i,
   input  logic [CNT_W-1:0]       max_stall_i,
   input  logic [CNT_W-1:0]       boost_len_i,
   input  logic [NB_REQUESTS-1:0] req_i,
   input  logic [NB_REQUESTS-1:0] gnt_i,
   output logic                   invert_prio_o,
   output logic [IDW-1:0]         boost_id_o,
   output logic                   boost_active_o,
   output logic [NB_REQUESTS-1:0] starving_o
`ifdef HCI_ARB_SCHED_STATS_EN
   ,
   input  logic [IDW-1:0]                   stat_sel_i,
   output logic [HCI_ARB_SCHED_STAT_W-1:0]  stat_stall_o,
   output logic [HCI_ARB_SCHED_BOOST_W-1:0] stat_boosts_o
`endif
);

   localparam int unsigned COOL_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

   hci_arb_sched_state_e r_state, w_state_nxt;

   logic [NB_REQUESTS-1:0] w_stall;
   logic [NB_REQUESTS-1:0] w_starving;
   logic [CNT_W-1:0]       w_cnt [NB_REQUESTS];
   logic                   w_any_starving;
   logic [IDW-1:0]         w_low_id;

   logic [CNT_W-1:0]  r_win, w_win_nxt, w_win_last;
   logic [COOL_W-1:0] r_cool, w_cool_nxt;
   logic [IDW-1:0]    r_boost_id, w_boost_id_nxt;
   logic              r_invert, w_invert_nxt;
   logic              w_boost_exit, w_cool_done;

   // Per-requester stall counters: count while waiting, restart on grant or idle.
   for (genvar g = 0; g < NB_REQUESTS; g++) begin : g_stall
      assign w_stall[g]    = req_i[g] & ~gnt_i[g];
      assign w_starving[g] = (max_stall_i != '0) && (w_cnt[g] >= max_stall_i);

      hci_stall_counter #(.W(CNT_W)) u_stall_cnt (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .clear_i (clear_i | ~w_stall[g]),
         .inc_i   (w_stall[g]),
         .cnt_o   (w_cnt[g])
      );
   end

   assign w_any_starving = |w_starving;

   // Lowest starving index wins the boost.
   always_comb begin
      w_low_id = '0;
      for (int i = NB_REQUESTS - 1; i >= 0; i--) begin
         if (w_starving[i]) w_low_id = IDW'(i);
      end
   end

   assign w_win_last   = (boost_len_i == '0) ? '0 : (boost_len_i - CNT_W'(1));
   assign w_boost_exit = gnt_i[r_boost_id] | ~req_i[r_boost_id] | (r_win == w_win_last);
   assign w_cool_done  = (r_cool == COOL_W'(COOLDOWN_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= NORMAL;
      end else if (clear_i) begin
         r_state <= NORMAL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!enable_i) begin
         w_state_nxt = NORMAL;
      end else begin
         unique case (r_state)
            NORMAL:   if (w_any_starving) w_state_nxt = BOOST;
            BOOST:    if (w_boost_exit)   w_state_nxt = COOLDOWN;
            COOLDOWN: if (w_cool_done)    w_state_nxt = NORMAL;
            default:                      w_state_nxt = NORMAL;
         endcase
      end
   end

   // Next values of the registered outputs and window/cooldown timers.
   always_comb begin
      w_invert_nxt   = (w_state_nxt == BOOST);
      w_boost_id_nxt = r_boost_id;
      w_win_nxt      = r_win;
      w_cool_nxt     = r_cool;
      if ((r_state == NORMAL) && (w_state_nxt == BOOST)) begin
         w_boost_id_nxt = w_low_id;
         w_win_nxt      = '0;
      end
      if ((r_state == BOOST) && (w_state_nxt == BOOST)) begin
         w_win_nxt = r_win + CNT_W'(1);
      end
      if ((r_state == BOOST) && (w_state_nxt == COOLDOWN)) begin
         w_cool_nxt = '0;
      end
      if ((r_state == COOLDOWN) && (w_state_nxt == COOLDOWN)) begin
         w_cool_nxt = r_cool + COOL_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_invert   <= 1'b0;
         r_boost_id <= '0;
         r_win      <= '0;
         r_cool     <= '0;
      end else if (clear_i) begin
         r_invert   <= 1'b0;
         r_boost_id <= '0;
         r_win      <= '0;
         r_cool     <= '0;
      end else begin
         r_invert   <= w_invert_nxt;
         r_boost_id <= w_boost_id_nxt;
         r_win      <= w_win_nxt;
         r_cool     <= w_cool_nxt;
      end
   end

   assign invert_prio_o  = r_invert;
   assign boost_id_o     = r_boost_id;
   assign boost_active_o = (r_state == BOOST);
   assign starving_o     = w_starving;

`ifdef HCI_ARB_SCHED_STATS_EN
   logic [HCI_ARB_SCHED_STAT_W-1:0] w_total [NB_REQUESTS];
   logic                            w_boost_start;

   assign w_boost_start = (r_state == NORMAL) && (w_state_nxt == BOOST);

   for (genvar g = 0; g < NB_REQUESTS; g++) begin : g_stat
      hci_stall_counter #(.W(HCI_ARB_SCHED_STAT_W)) u_total_cnt (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .clear_i (clear_i),
         .inc_i   (w_stall[g]),
         .cnt_o   (w_total[g])
      );
   end

   hci_stall_counter #(.W(HCI_ARB_SCHED_BOOST_W)) u_boost_cnt (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .inc_i   (w_boost_start),
      .cnt_o   (stat_boosts_o)
   );

   always_comb begin
      stat_stall_o = '0;
      for (int i = 0; i < NB_REQUESTS; i++) begin
         if (stat_sel_i == IDW'(i)) stat_stall_o = w_total[i];
      end
   end
`endif

endmodule

// File: tb/tb_hci_arbiter_tree_sched.sv
// Self-checking bench for hci_arbiter_tree_sched: directed scenarios then random traffic vs a behavioural model.
// Statistics checks are compiled in when HCI_ARB_SCHED_STATS_EN is defined.
module tb_hci_arbiter_tree_sched;

   localparam int NB   = 4;
   localparam int CW   = 8;
   localparam int COOL = 4;
   localparam int IW   = $clog2(NB);

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          clear_i;
   logic          enable_i;
   logic [CW-1:0] max_stall_i;
   logic [CW-1:0] boost_len_i;
   logic [NB-1:0] req_i;
   logic [NB-1:0] gnt_i;
   logic          invert_prio_o;
   logic [IW-1:0] boost_id_o;
   logic          boost_active_o;
   logic [NB-1:0] starving_o;
`ifdef HCI_ARB_SCHED_STATS_EN
   logic [IW-1:0] stat_sel_i;
   logic [31:0]   stat_stall_o;
   logic [15:0]   stat_boosts_o;
`endif

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model: mode 0=normal, 1=boosting, 2=cooling down.
   int      m_cnt [NB];
   int      m_mode;
   int      m_id;
   int      m_win;
   int      m_cool;
   bit      m_inv;
   longint  m_tot [NB];
   int      m_boosts;

   hci_arbiter_tree_sched #(
      .NB_REQUESTS     (NB),
      .CNT_W           (CW),
      .COOLDOWN_CYCLES (COOL)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .enable_i       (enable_i),
      .max_stall_i    (max_stall_i),
      .boost_len_i    (boost_len_i),
      .req_i          (req_i),
      .gnt_i          (gnt_i),
      .invert_prio_o  (invert_prio_o),
      .boost_id_o     (boost_id_o),
      .boost_active_o (boost_active_o),
      .starving_o     (starving_o)
`ifdef HCI_ARB_SCHED_STATS_EN
      ,
      .stat_sel_i     (stat_sel_i),
      .stat_stall_o   (stat_stall_o),
      .stat_boosts_o  (stat_boosts_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic logic [NB-1:0] m_starving();
      logic [NB-1:0] s;
      s = '0;
      for (int i = 0; i < NB; i++) s[i] = (max_stall_i != 0) && (m_cnt[i] >= int'(max_stall_i));
      return s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         m_cnt[i] = 0;
         m_tot[i] = 0;
      end
      m_mode   = 0;
      m_id     = 0;
      m_win    = 0;
      m_cool   = 0;
      m_inv    = 1'b0;
      m_boosts = 0;
   endtask

   task automatic model_step();
      logic [NB-1:0] st;
      int            len;
      int            lowest;
      if (clear_i) begin
         model_reset();
         return;
      end
      st     = m_starving();
      len    = (boost_len_i == 0) ? 1 : int'(boost_len_i);
      lowest = -1;
      for (int i = NB - 1; i >= 0; i--) if (st[i]) lowest = i;
      if (!enable_i) begin
         m_mode = 0;
         m_inv  = 1'b0;
      end else if (m_mode == 0) begin
         if (lowest >= 0) begin
            m_mode = 1;
            m_id   = lowest;
            m_win  = 0;
            m_inv  = 1'b1;
            if (m_boosts < 65535) m_boosts++;
         end
      end else if (m_mode == 1) begin
         if (gnt_i[m_id] || !req_i[m_id] || (m_win == len - 1)) begin
            m_mode = 2;
            m_cool = 0;
            m_inv  = 1'b0;
         end else begin
            m_win++;
         end
      end else begin
         if (m_cool == COOL - 1) m_mode = 0;
         else m_cool++;
      end
      for (int i = 0; i < NB; i++) begin
         if (req_i[i] && !gnt_i[i]) begin
            if (m_cnt[i] < 255) m_cnt[i]++;
            if (m_tot[i] < 64'hFFFF_FFFF) m_tot[i]++;
         end else begin
            m_cnt[i] = 0;
         end
      end
   endtask

   task automatic check_all();
      check("invert_prio", 32'(invert_prio_o), 32'(m_inv));
      check("boost_active", 32'(boost_active_o), 32'(m_mode == 1));
      check("boost_id", 32'(boost_id_o), 32'(m_id));
      check("starving", 32'(starving_o), 32'(m_starving()));
`ifdef HCI_ARB_SCHED_STATS_EN
      check("stat_stall", stat_stall_o, 32'(m_tot[stat_sel_i]));
      check("stat_boosts", 32'(stat_boosts_o), 32'(m_boosts));
`endif
   endtask

   task automatic step();
      @(posedge clk_i);
      model_step();
      #1;
      check_all();
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      req_i   = '0;
      gnt_i   = '0;
      step();
      clear_i = 1'b0;
   endtask

   initial begin
      rst_ni      = 1'b0;
      clear_i     = 1'b0;
      enable_i    = 1'b1;
      max_stall_i = 8'd3;
      boost_len_i = 8'd8;
      req_i       = 4'b1111;
      gnt_i       = '0;
`ifdef HCI_ARB_SCHED_STATS_EN
      stat_sel_i  = '0;
`endif
      model_reset();

      // Reset with everyone requesting: all outputs quiet.
      #12;
      check("reset_invert", 32'(invert_prio_o), 32'd0);
      check("reset_active", 32'(boost_active_o), 32'd0);
      check("reset_id", 32'(boost_id_o), 32'd0);
      check("reset_starving", 32'(starving_o), 32'd0);
      req_i  = '0;
      rst_ni = 1'b1;

      // Basic boost on requester 1, granted in cycle 6.
      req_i = 4'b0010;
      repeat (3) step();
      check("basic_starve_c3", 32'(starving_o), 32'b0010);
      step();
      check("basic_invert_c4", 32'(invert_prio_o), 32'd1);
      check("basic_id_c4", 32'(boost_id_o), 32'd1);
      repeat (2) step();
      gnt_i = 4'b0010;
      step();
      check("basic_invert_c7", 32'(invert_prio_o), 32'd0);
      gnt_i = '0;
      req_i = '0;
      repeat (6) step();

      // Window expiry: five BOOST cycles, cooldown, immediate re-boost.
      do_clear();
      boost_len_i = 8'd5;
      req_i       = 4'b0010;
      repeat (4) step();
      check("win_enter", 32'(boost_active_o), 32'd1);
      repeat (4) step();
      check("win_last", 32'(boost_active_o), 32'd1);
      step();
      check("win_exit", 32'(boost_active_o), 32'd0);
      repeat (4) step();
      check("win_normal_starving", 32'(starving_o), 32'b0010);
      check("win_normal_idle", 32'(boost_active_o), 32'd0);
      step();
      check("win_reboost", 32'(boost_active_o), 32'd1);

      // Two requesters starve together: lower index wins.
      do_clear();
      req_i = 4'b1010;
      repeat (3) step();
      check("tie_starving", 32'(starving_o), 32'b1010);
      step();
      check("tie_id", 32'(boost_id_o), 32'd1);

      // Threshold 0 disables boosting; counters still saturate at 255.
      do_clear();
      max_stall_i = 8'd0;
      req_i       = 4'b1111;
      repeat (260) step();
      max_stall_i = 8'd255;
      #1;
      check("sat_starving", 32'(starving_o), 32'b1111);
      max_stall_i = 8'd3;
      boost_len_i = 8'd20;
      step();
      check("dis_boost", 32'(boost_active_o), 32'd1);
      enable_i = 1'b0;
      step();
      check("dis_active", 32'(boost_active_o), 32'd0);
      check("dis_invert", 32'(invert_prio_o), 32'd0);
      enable_i = 1'b1;

`ifdef HCI_ARB_SCHED_STATS_EN
      // Ten stall cycles on requester 0 with one boost event.
      do_clear();
      max_stall_i = 8'd3;
      boost_len_i = 8'd20;
      stat_sel_i  = '0;
      req_i       = 4'b0001;
      repeat (10) step();
      gnt_i = 4'b0001;
      step();
      gnt_i = '0;
      req_i = '0;
      check("stat_stall_10", stat_stall_o, 32'd10);
      check("stat_boosts_1", 32'(stat_boosts_o), 32'd1);
      do_clear();
      check("stat_stall_clr", stat_stall_o, 32'd0);
      check("stat_boosts_clr", 32'(stat_boosts_o), 32'd0);
`endif

      // Random traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         clear_i  = ($urandom_range(0, 99) == 0);
         enable_i = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 15) == 0) max_stall_i = CW'($urandom_range(0, 6));
         if ($urandom_range(0, 15) == 0) boost_len_i = CW'($urandom_range(0, 6));
         if ($urandom_range(0, 3) == 0) req_i = NB'($urandom);
         gnt_i = req_i & NB'($urandom) & NB'($urandom) & NB'($urandom);
`ifdef HCI_ARB_SCHED_STATS_EN
         stat_sel_i = IW'($urandom);
`endif
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
